// File: rtl/qdr_cmd_bridge.sv
// rtl/qdr_cmd_bridge.sv - user command FIFO bridged onto the sniffer slave port, one strobe at a time
// Optional acked-command counters (wr_count/rd_count) are built when QDR_CMD_BRIDGE_STATS_EN is defined.

module qdr_cmd_bridge #(
  parameter int CMD_DEPTH  = 16,
  parameter int MAX_RD_OUT = 8
) (
  input  logic        qdr_clk,
  input  logic        qdr_rst_n,
  input  logic        user_wr_en,
  input  logic        user_rd_en,
  input  logic [31:0] user_addr,
  input  logic [35:0] user_wr_data,
  input  logic [3:0]  user_wr_be,
  output logic        user_ready,
  output logic [35:0] user_rd_data,
  output logic        user_rd_valid,
  output logic [31:0] slave_addr,
  output logic        slave_wr_strb,
  output logic [35:0] slave_wr_data,
  output logic [3:0]  slave_wr_be,
  output logic        slave_rd_strb,
  input  logic        slave_ack,
  input  logic [35:0] slave_rd_data,
  input  logic        slave_rd_dvld,
  input  logic        phy_rdy,
  output logic [2:0]  err_flags
`ifdef QDR_CMD_BRIDGE_STATS_EN
  ,
  output logic [31:0] wr_count,
  output logic [31:0] rd_count
`endif
);

  localparam int         AW       = $clog2(CMD_DEPTH);
  localparam int         EW       = 73;
  localparam logic [3:0] RD_LIMIT = 4'(MAX_RD_OUT);

  typedef enum logic [1:0] {WAIT_PHY, RUN, HOLD} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [EW-1:0] r_mem [CMD_DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [3:0]    r_rd_out;
  logic [2:0]    r_err;
  logic [EW-1:0] w_head;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_issue;
  logic          w_ack;
  logic          w_head_wr;
  logic          w_rd_block;
  logic          w_inc;
  logic          w_dec;

  // Entry layout: {is_write, addr[31:0], data[35:0], be[3:0]}
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_wr  = w_head[EW-1];
  assign w_rd_block = !w_head_wr && (r_rd_out >= RD_LIMIT);
  // HOLD keeps accepting so the FIFO can fill behind a stalled slave.
  assign user_ready = (r_state != WAIT_PHY) && !w_full;
  assign w_push     = (user_wr_en || user_rd_en) && user_ready;
  assign w_ack      = (r_state == HOLD) && slave_ack;
  assign w_inc      = w_ack && slave_rd_strb;
  assign w_dec      = slave_rd_dvld && (r_rd_out != 4'd0);
  assign err_flags  = r_err;

  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) r_state <= WAIT_PHY;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    case (r_state)
      WAIT_PHY: if (phy_rdy) w_state_nxt = RUN;
      RUN: begin
        if (phy_rdy && !w_empty && !w_rd_block) begin
          w_issue     = 1'b1;
          w_state_nxt = HOLD;
        end else if (!phy_rdy) begin
          w_state_nxt = WAIT_PHY;
        end
      end
      HOLD:     if (slave_ack) w_state_nxt = phy_rdy ? RUN : WAIT_PHY;
      default:  w_state_nxt = WAIT_PHY;
    endcase
  end

  always_ff @(posedge qdr_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {user_wr_en, user_addr, user_wr_data, user_wr_be};
  end

  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      slave_wr_strb <= 1'b0;
      slave_rd_strb <= 1'b0;
      slave_addr    <= '0;
      slave_wr_data <= '0;
      slave_wr_be   <= '0;
    end else if (w_issue) begin
      slave_wr_strb <= w_head_wr;
      slave_rd_strb <= !w_head_wr;
      slave_addr    <= w_head[71:40];
      slave_wr_data <= w_head[39:4];
      slave_wr_be   <= w_head[3:0];
    end else if (w_ack) begin
      slave_wr_strb <= 1'b0;
      slave_rd_strb <= 1'b0;
    end
  end

  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      r_rd_out <= 4'd0;
      r_err    <= 3'b000;
    end else begin
      case ({w_inc, w_dec})
        2'b10:   r_rd_out <= r_rd_out + 4'd1;
        2'b01:   r_rd_out <= r_rd_out - 4'd1;
        default: r_rd_out <= r_rd_out;
      endcase
      if ((user_wr_en || user_rd_en) && (r_state != WAIT_PHY) && w_full) r_err[0] <= 1'b1;
      if (user_wr_en && user_rd_en && user_ready)                        r_err[1] <= 1'b1;
      if (slave_rd_dvld && (r_rd_out == 4'd0))                           r_err[2] <= 1'b1;
    end
  end

  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      user_rd_valid <= 1'b0;
      user_rd_data  <= '0;
    end else begin
      user_rd_valid <= slave_rd_dvld;
      if (slave_rd_dvld) user_rd_data <= slave_rd_data;
    end
  end

`ifdef QDR_CMD_BRIDGE_STATS_EN
  always_ff @(posedge qdr_clk or negedge qdr_rst_n) begin
    if (!qdr_rst_n) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (w_ack && slave_wr_strb) wr_count <= wr_count + 32'd1;
      if (w_inc)                  rd_count <= rd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qdr_cmd_bridge.sv
// tb/tb_qdr_cmd_bridge.sv - scoreboard bench for qdr_cmd_bridge: directed scenarios plus randomized traffic
`timescale 1ns/1ps

module tb_qdr_cmd_bridge;
  localparam int DEPTH = 16;
  localparam int MAXRD = 8;

  logic        qdr_clk = 1'b0;
  logic        qdr_rst_n = 1'b0;
  logic        user_wr_en = 1'b0;
  logic        user_rd_en = 1'b0;
  logic [31:0] user_addr = '0;
  logic [35:0] user_wr_data = '0;
  logic [3:0]  user_wr_be = '0;
  logic        user_ready;
  logic [35:0] user_rd_data;
  logic        user_rd_valid;
  logic [31:0] slave_addr;
  logic        slave_wr_strb;
  logic [35:0] slave_wr_data;
  logic [3:0]  slave_wr_be;
  logic        slave_rd_strb;
  logic        slave_ack = 1'b0;
  logic [35:0] slave_rd_data = '0;
  logic        slave_rd_dvld = 1'b0;
  logic        phy_rdy = 1'b0;
  logic [2:0]  err_flags;
`ifdef QDR_CMD_BRIDGE_STATS_EN
  logic [31:0] wr_count;
  logic [31:0] rd_count;
`endif

  qdr_cmd_bridge #(.CMD_DEPTH(DEPTH), .MAX_RD_OUT(MAXRD)) dut (
    .qdr_clk(qdr_clk), .qdr_rst_n(qdr_rst_n),
    .user_wr_en(user_wr_en), .user_rd_en(user_rd_en), .user_addr(user_addr),
    .user_wr_data(user_wr_data), .user_wr_be(user_wr_be), .user_ready(user_ready),
    .user_rd_data(user_rd_data), .user_rd_valid(user_rd_valid),
    .slave_addr(slave_addr), .slave_wr_strb(slave_wr_strb), .slave_wr_data(slave_wr_data),
    .slave_wr_be(slave_wr_be), .slave_rd_strb(slave_rd_strb), .slave_ack(slave_ack),
    .slave_rd_data(slave_rd_data), .slave_rd_dvld(slave_rd_dvld), .phy_rdy(phy_rdy),
    .err_flags(err_flags)
`ifdef QDR_CMD_BRIDGE_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  always #5 qdr_clk = ~qdr_clk;

  typedef struct {bit wr; logic [31:0] a; logic [35:0] d; logic [3:0] be;} cmd_t;
  typedef struct {logic [35:0] d; int c;} rdr_t;

  cmd_t exp_cmd[$];
  rdr_t exp_rd[$];
  int   n_chk = 0, n_pass = 0;
  int   accepted = 0, issued = 0, model_out = 0, out_dec = 0, cyc = 0;
  int   hi_len = 0, last_hi_len = 0, n_wr_iss = 0, n_rd_iss = 0;
  bit   model_run = 0, prev_strobe = 0, strobe = 0, exp_ready = 0;
  logic [2:0]  exp_err = '0;
  logic [31:0] h_addr = '0;
  logic [35:0] h_data = '0;
  logic [3:0]  h_be = '0;
  bit   h_wr = 0;
  bit   auto_ack = 0, man_ack = 0;
  int   lat_max = 0, ack_wait = 0;
  cmd_t mc;
  rdr_t mr;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [35:0] rnd36();
    return {4'($urandom_range(0, 15)), 32'($urandom)};
  endfunction

  // Slave responder: immediate/random-latency acks, or a level driven by the scenario.
  always @(posedge qdr_clk) begin
    #2;
    if (auto_ack) begin
      if ((slave_wr_strb || slave_rd_strb) && !slave_ack) begin
        if (ack_wait == 0) begin
          slave_ack = 1'b1;
          ack_wait  = $urandom_range(0, lat_max);
        end else begin
          ack_wait--;
        end
      end else begin
        slave_ack = 1'b0;
      end
    end else begin
      slave_ack = man_ack;
    end
  end

  // Monitor and reference model: commands leave in acceptance order, reads limited by acked-minus-returned.
  always @(negedge qdr_clk) begin
    if (!qdr_rst_n) begin
      exp_cmd.delete();
      exp_rd.delete();
      accepted = 0; issued = 0; model_out = 0; out_dec = 0;
      exp_err = '0; model_run = 0; prev_strobe = 0; hi_len = 0;
      chk(!slave_wr_strb && !slave_rd_strb && !user_rd_valid && !user_ready && err_flags == 3'b0 && slave_addr == 32'h0,
          "reset_outputs", {24'h0, slave_wr_strb, slave_rd_strb, user_rd_valid, user_ready, err_flags, slave_addr}, 64'h0);
    end else begin
      strobe = slave_wr_strb || slave_rd_strb;
      chk(!(slave_wr_strb && slave_rd_strb), "dual_strobe", {slave_wr_strb, slave_rd_strb}, 0);
      if (strobe && !prev_strobe) begin
        issued++;
        if (slave_wr_strb) n_wr_iss++; else n_rd_iss++;
        if (exp_cmd.size() == 0) begin
          chk(0, "unexpected_issue", slave_addr, 0);
        end else begin
          mc = exp_cmd.pop_front();
          chk(mc.wr == slave_wr_strb && mc.a == slave_addr, "issue_order",
              {slave_wr_strb, slave_addr}, {mc.wr, mc.a});
          if (mc.wr)
            chk(mc.d == slave_wr_data && mc.be == slave_wr_be, "issue_wdata",
                {slave_wr_be, slave_wr_data}, {mc.be, mc.d});
        end
        if (slave_rd_strb) chk(out_dec < MAXRD, "rd_limit", out_dec, MAXRD);
        h_wr = slave_wr_strb; h_addr = slave_addr; h_data = slave_wr_data; h_be = slave_wr_be;
        hi_len = 1;
      end else if (strobe) begin
        hi_len++;
        chk(h_wr == slave_wr_strb && h_addr == slave_addr && h_data == slave_wr_data && h_be == slave_wr_be,
            "hold_stable", slave_addr, h_addr);
      end else if (prev_strobe) begin
        last_hi_len = hi_len;
      end

      if (user_rd_valid) begin
        if (exp_rd.size() == 0) begin
          chk(0, "unexpected_rd_valid", user_rd_data, 0);
        end else begin
          mr = exp_rd.pop_front();
          chk(mr.d == user_rd_data && mr.c == cyc - 1, "rd_return", user_rd_data, mr.d);
        end
      end

      exp_ready = model_run && (accepted - issued < DEPTH);
      chk(user_ready == exp_ready, "user_ready", user_ready, exp_ready);
      chk(err_flags == exp_err, "err_flags", err_flags, exp_err);

      out_dec = model_out;
      if (slave_rd_dvld) begin
        if (model_out == 0) exp_err[2] = 1'b1;
        else model_out--;
        mr.d = slave_rd_data; mr.c = cyc;
        exp_rd.push_back(mr);
      end
      if (slave_ack && slave_rd_strb) model_out++;
      if ((user_wr_en || user_rd_en) && model_run) begin
        if (accepted - issued < DEPTH) begin
          accepted++;
          mc.wr = user_wr_en; mc.a = user_addr; mc.d = user_wr_data; mc.be = user_wr_be;
          exp_cmd.push_back(mc);
          if (user_wr_en && user_rd_en) exp_err[1] = 1'b1;
        end else begin
          exp_err[0] = 1'b1;
        end
      end
      model_run = phy_rdy || (strobe && !slave_ack);
      prev_strobe = strobe;
      cyc++;
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) begin
      @(posedge qdr_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    user_wr_en = 0; user_rd_en = 0; slave_rd_dvld = 0;
    qdr_rst_n = 0;
    cyc_n(3);
    chk(slave_wr_data == 36'h0 && user_rd_data == 36'h0 && slave_wr_be == 4'h0 && !user_ready,
        "reset_data", {slave_wr_be, slave_wr_data}, 0);
    qdr_rst_n = 1;
  endtask

  task automatic send(input bit w, input bit r, input logic [31:0] a, input logic [35:0] d, input logic [3:0] be);
    int t = 0;
    user_wr_en = w; user_rd_en = r; user_addr = a; user_wr_data = d; user_wr_be = be;
    while (!user_ready && t < 200) begin
      cyc_n(1);
      t++;
    end
    if (t >= 200) chk(0, "send_timeout", t, 200);
    cyc_n(1);
    user_wr_en = 0; user_rd_en = 0;
  endtask

  task automatic wait_done(input bit feed);
    int t = 0;
    while ((exp_cmd.size() != 0 || slave_wr_strb || slave_rd_strb) && t < 3000) begin
      slave_rd_dvld = feed && (model_out > 0) && ($urandom_range(0, 1) == 1);
      slave_rd_data = rnd36();
      cyc_n(1);
      t++;
    end
    slave_rd_dvld = 0;
    chk(t < 3000, "drain_timeout", t, 3000);
  endtask

  task automatic drain_out();
    int t = 0;
    while (model_out > 0 && t < 100) begin
      slave_rd_dvld = 1; slave_rd_data = rnd36();
      cyc_n(1);
      t++;
    end
    slave_rd_dvld = 0;
    cyc_n(2);
  endtask

  initial begin
    int base, t;
    int r;

    // Reset, then requests with the PHY not ready are silently dropped
    do_reset();
    phy_rdy = 0;
    user_wr_en = 1; user_addr = 32'h44;
    cyc_n(3);
    user_wr_en = 0;
    cyc_n(2);
    chk(user_ready == 1'b0, "wait_phy_ready", user_ready, 0);
    chk(n_wr_iss + n_rd_iss == 0, "wait_phy_no_strobe", n_wr_iss + n_rd_iss, 0);
    chk(err_flags == 3'b000, "wait_phy_err", err_flags, 0);

    // Single write held for four cycles by a late ack
    phy_rdy = 1;
    cyc_n(2);
    send(1, 0, 32'h10, 36'h123456789, 4'hF);
    t = 0;
    while (!slave_wr_strb && t < 20) begin cyc_n(1); t++; end
    chk(t < 20, "wr_strobe_seen", t, 20);
    cyc_n(3);
    man_ack = 1;
    cyc_n(1);
    man_ack = 0;
    cyc_n(2);
    chk(last_hi_len == 4, "wr_strobe_len", last_hi_len, 4);
`ifdef QDR_CMD_BRIDGE_STATS_EN
    chk(wr_count == 32'd1, "stats_wr_count", wr_count, 1);
`endif

    // Nine reads against a limit of eight outstanding
    base = n_rd_iss;
    auto_ack = 1; lat_max = 0;
    for (int i = 0; i < 9; i++) send(0, 1, 32'h200 + 32'(i), rnd36(), 4'h0);
    cyc_n(20);
    chk(n_rd_iss - base == 8, "rd_held_off", n_rd_iss - base, 8);
    slave_rd_dvld = 1; slave_rd_data = 36'hABC;
    cyc_n(1);
    slave_rd_dvld = 0;
    cyc_n(10);
    chk(n_rd_iss - base == 9, "rd_after_dvld", n_rd_iss - base, 9);
    drain_out();

    // FIFO fills behind a stalled slave; an extra push overflows
    do_reset();
    phy_rdy = 1; auto_ack = 0; man_ack = 0;
    cyc_n(2);
    base = n_wr_iss;
    for (int i = 0; i < 17; i++) send(1, 0, 32'h100 + 32'(i), rnd36(), 4'($urandom_range(0, 15)));
    chk(user_ready == 1'b0, "full_ready", user_ready, 0);
    user_wr_en = 1; user_addr = 32'hDEAD;
    cyc_n(1);
    user_wr_en = 0;
    cyc_n(1);
    chk(err_flags == 3'b001, "overflow_flag", err_flags, 3'b001);
    auto_ack = 1; lat_max = 2;
    wait_done(0);
    chk(n_wr_iss - base == 17, "full_all_issued", n_wr_iss - base, 17);

    // Write/read collision, then an orphan read return
    do_reset();
    phy_rdy = 1;
    cyc_n(2);
    base = n_rd_iss;
    send(1, 1, 32'h300, 36'h5A5A5A5A5, 4'h3);
    wait_done(0);
    cyc_n(2);
    chk(err_flags == 3'b010, "collision_flag", err_flags, 3'b010);
    chk(n_rd_iss - base == 0, "collision_no_rd", n_rd_iss - base, 0);
    slave_rd_dvld = 1; slave_rd_data = rnd36();
    cyc_n(1);
    slave_rd_dvld = 0;
    cyc_n(2);
    chk(err_flags == 3'b110, "orphan_flag", err_flags, 3'b110);

    // Reset asserted while a write is held, with one read outstanding
    do_reset();
    phy_rdy = 1;
    cyc_n(2);
    send(0, 1, 32'h400, rnd36(), 4'h0);
    wait_done(0);
    auto_ack = 0; man_ack = 0;
    send(1, 0, 32'h404, 36'hFFFFFFFFF, 4'hF);
    t = 0;
    while (!slave_wr_strb && t < 20) begin cyc_n(1); t++; end
    chk(t < 20, "hold_reached", t, 20);
    cyc_n(1);
    #2 qdr_rst_n = 0;
    #1;
    chk(!slave_wr_strb && !slave_rd_strb && slave_addr == 32'h0 && slave_wr_data == 36'h0 && slave_wr_be == 4'h0 &&
        err_flags == 3'b0 && !user_rd_valid && !user_ready, "async_reset",
        {slave_wr_strb, slave_rd_strb, slave_addr}, 0);
`ifdef QDR_CMD_BRIDGE_STATS_EN
    chk(wr_count == 32'd0, "stats_reset", wr_count, 0);
`endif
    cyc_n(1);
    qdr_rst_n = 1;
    cyc_n(2);
    slave_rd_dvld = 1; slave_rd_data = rnd36();
    cyc_n(1);
    slave_rd_dvld = 0;
    cyc_n(2);
    chk(err_flags == 3'b100, "orphan_after_reset", err_flags, 3'b100);

    // Randomized traffic with PHY drops, random ack latency and read returns
    auto_ack = 1; lat_max = 3;
    repeat (400) begin
      r = int'($urandom_range(0, 99));
      user_wr_en    = (r < 35);
      user_rd_en    = (r >= 30) && (r < 60);
      user_addr     = $urandom;
      user_wr_data  = rnd36();
      user_wr_be    = 4'($urandom_range(0, 15));
      slave_rd_dvld = (model_out > 0) && ($urandom_range(0, 99) < 30);
      slave_rd_data = rnd36();
      phy_rdy       = ($urandom_range(0, 99) >= 4);
      cyc_n(1);
    end
    user_wr_en = 0; user_rd_en = 0; slave_rd_dvld = 0; phy_rdy = 1;
    wait_done(1);
    drain_out();
    chk(exp_rd.size() == 0, "rd_queue_empty", exp_rd.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
